// File: rtl/sd_cmd_tx_ctrl_if.sv
// Host-side bus of the SD CMD transmitter: request handshake, command fields,
// status flags and the serial CMD pad signals.
interface sd_cmd_tx_ctrl_if;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        ready;
  logic        busy;
  logic        done;
  logic        cmd_out;
  logic        cmd_oe;

  modport master (
    output start, cmd_index, cmd_arg,
    input  ready, busy, done, cmd_out, cmd_oe
  );

  modport slave (
    input  start, cmd_index, cmd_arg,
    output ready, busy, done, cmd_out, cmd_oe
  );
endinterface

// File: rtl/sd_cmd_tx_ctrl.sv
// SD command frame transmitter: start/tx bits, index, argument, on-the-fly CRC7
// and end bit shifted out MSB-first with an output enable.
module sd_cmd_tx_ctrl #(
  parameter int BITS         = 48,
  parameter int BITS_COUNTER = 6
) (
  input  logic              clk,
  input  logic              reset,
  sd_cmd_tx_ctrl_if.slave   bus
);

  localparam int HDR_BITS = BITS - 8;
  localparam int CRC_BITS = 7;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HDR,
    SEND_CRC,
    SEND_END,
    DONE
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [HDR_BITS-1:0]     shift;
  logic [6:0]              crc;
  logic [6:0]              crc_next;
  logic [BITS_COUNTER-1:0] counter;
  logic                    hdr_last;
  logic                    crc_last;
  logic                    fb;

  assign hdr_last = (counter == BITS_COUNTER'(HDR_BITS - 1));
  assign crc_last = (counter == BITS_COUNTER'(CRC_BITS - 1));
  assign fb       = shift[HDR_BITS-1] ^ crc[6];
  assign crc_next = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    bus.ready   = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.cmd_out = 1'b1;
    bus.cmd_oe  = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          next_state = SEND_HDR;
        end
      end
      SEND_HDR: begin
        bus.busy    = 1'b1;
        bus.cmd_oe  = 1'b1;
        bus.cmd_out = shift[HDR_BITS-1];
        if (hdr_last) begin
          next_state = SEND_CRC;
        end
      end
      SEND_CRC: begin
        bus.busy    = 1'b1;
        bus.cmd_oe  = 1'b1;
        bus.cmd_out = crc[6];
        if (crc_last) begin
          next_state = SEND_END;
        end
      end
      SEND_END: begin
        bus.busy   = 1'b1;
        bus.cmd_oe = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The CRC absorbs each header bit as it is driven, then is itself shifted out.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift   <= '0;
      crc     <= '0;
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          counter <= '0;
          if (bus.start) begin
            shift <= {2'b01, bus.cmd_index, bus.cmd_arg};
            crc   <= '0;
          end
        end
        SEND_HDR: begin
          shift   <= {shift[HDR_BITS-2:0], 1'b0};
          crc     <= crc_next;
          counter <= hdr_last ? '0 : counter + BITS_COUNTER'(1);
        end
        SEND_CRC: begin
          crc     <= {crc[5:0], 1'b0};
          counter <= crc_last ? '0 : counter + BITS_COUNTER'(1);
        end
        default: begin
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx_ctrl.sv
// Self-checking bench for sd_cmd_tx_ctrl: directed frames with known CRCs plus
// randomized commands checked against a frame-level reference model.
module tb_sd_cmd_tx_ctrl;

  localparam int MAXC   = 200;
  localparam int PERIOD = 50;

  logic clk = 1'b0;
  logic reset;
  int   assertions = 0;
  int   failures   = 0;

  logic rec_oe    [0:MAXC-1];
  logic rec_out   [0:MAXC-1];
  logic rec_done  [0:MAXC-1];
  logic rec_ready [0:MAXC-1];
  logic rec_busy  [0:MAXC-1];

  int drop_at = 0;
  int mid_at  = -5;
  int rst_at  = -5;

  always #5 clk = ~clk;

  sd_cmd_tx_ctrl_if bus ();

  sd_cmd_tx_ctrl #(.BITS(48), .BITS_COUNTER(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference frame: header, CRC7 over the 40 header bits, end bit.
  function automatic logic [47:0] frameOf(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] hdr;
    logic [6:0]  c;
    logic        f;
    hdr = {2'b01, idx, arg};
    c   = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      f = hdr[i] ^ c[6];
      c = {c[5:0], 1'b0} ^ (f ? 7'h09 : 7'h00);
    end
    return {hdr, c, 1'b1};
  endfunction

  task automatic captureCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rec_oe[i]    = bus.cmd_oe;
      rec_out[i]   = bus.cmd_out;
      rec_done[i]  = bus.done;
      rec_ready[i] = bus.ready;
      rec_busy[i]  = bus.busy;
      if (i == drop_at) bus.start = 1'b0;
      if (i == mid_at) begin
        bus.start   = 1'b1;
        bus.cmd_arg = 32'hFFFF_FFFF;
      end
      if (i == mid_at + 1) bus.start = 1'b0;
      if (i == rst_at) reset = 1'b1;
      if (i == rst_at + 1) reset = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input int nframes);
    @(negedge clk);
    checkOutput("acceptReady", 64'(bus.ready), 64'd1);
    bus.cmd_index = idx;
    bus.cmd_arg   = arg;
    bus.start     = 1'b1;
    drop_at       = (nframes - 1) * PERIOD;
    @(posedge clk);
    captureCycles(nframes * PERIOD + 2);
  endtask

  task automatic checkFrameAt(input string tag, input int off, input logic [47:0] expected);
    logic [47:0] got;
    int oe_cnt, busy_cnt, stray;
    oe_cnt = 0; busy_cnt = 0; stray = 0;
    for (int k = 0; k < 48; k++) begin
      got[47-k] = rec_out[off+k];
      oe_cnt   += int'(rec_oe[off+k]);
      busy_cnt += int'(rec_busy[off+k]);
      stray    += int'(rec_ready[off+k]) + int'(rec_done[off+k]);
    end
    checkOutput({tag, ".bits"}, 64'(got), 64'(expected));
    checkOutput({tag, ".oeCycles"}, 64'(oe_cnt), 64'd48);
    checkOutput({tag, ".busyCycles"}, 64'(busy_cnt), 64'd48);
    checkOutput({tag, ".readyDoneInFrame"}, 64'(stray), 64'd0);
    checkOutput({tag, ".doneCycle"}, 64'({rec_done[off+48], rec_oe[off+48], rec_busy[off+48], rec_ready[off+48], rec_out[off+48]}), 64'b10001);
    checkOutput({tag, ".readyAgain"}, 64'({rec_ready[off+49], rec_oe[off+49], rec_done[off+49]}), 64'b100);
  endtask

  task automatic checkWindow(input string tag, input int len, input int exp_done, input int exp_oe);
    int d, o;
    d = 0; o = 0;
    for (int k = 0; k < len; k++) begin
      d += int'(rec_done[k]);
      o += int'(rec_oe[k]);
    end
    checkOutput({tag, ".doneCount"}, 64'(d), 64'(exp_done));
    checkOutput({tag, ".oeCount"}, 64'(o), 64'(exp_oe));
  endtask

  initial begin
    logic [47:0] exp_frame;
    logic [19:0] partial;
    logic [5:0]  ridx;
    logic [31:0] rarg;

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.cmd_index = 6'd0;
    bus.cmd_arg   = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetState", 64'({bus.ready, bus.busy, bus.done, bus.cmd_out, bus.cmd_oe}), 64'b10010);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idleHold", 64'({bus.ready, bus.busy, bus.done, bus.cmd_out, bus.cmd_oe}), 64'b10010);
    end

    $display("[TB] directed frames");
    applyStimulus(6'd0, 32'h0, 1);
    checkFrameAt("cmd0", 0, 48'h40_00000000_95);
    checkWindow("cmd0", PERIOD + 2, 1, 48);
    applyStimulus(6'd8, 32'h0000_01AA, 1);
    checkFrameAt("cmd8", 0, 48'h48_000001AA_87);
    applyStimulus(6'd17, 32'h0, 1);
    checkFrameAt("cmd17", 0, 48'h51_00000000_55);
    applyStimulus(6'd55, 32'h0, 1);
    checkFrameAt("cmd55", 0, 48'h77_00000000_65);

    $display("[TB] back-to-back frames");
    applyStimulus(6'd0, 32'h0, 3);
    for (int f = 0; f < 3; f++) begin
      checkFrameAt($sformatf("b2b%0d", f), f * PERIOD, 48'h40_00000000_95);
    end
    checkWindow("b2b", 3 * PERIOD + 2, 3, 144);

    $display("[TB] input change during frame");
    mid_at = 10;
    applyStimulus(6'd8, 32'h0000_01AA, 1);
    mid_at = -5;
    checkFrameAt("midChange", 0, 48'h48_000001AA_87);
    checkWindow("midChange", PERIOD + 2, 1, 48);

    $display("[TB] reset mid-frame");
    rst_at = 20;
    applyStimulus(6'd0, 32'h0, 1);
    rst_at = -5;
    exp_frame = 48'h40_00000000_95;
    for (int k = 0; k < 20; k++) partial[19-k] = rec_out[k];
    checkOutput("rstPartialBits", 64'(partial), 64'(exp_frame[47:28]));
    checkOutput("rstNextCycle", 64'({rec_oe[21], rec_out[21], rec_ready[21], rec_done[21], rec_busy[21]}), 64'b01100);
    checkWindow("rstAbandon", PERIOD + 2, 0, 21);
    applyStimulus(6'd0, 32'h0, 1);
    checkFrameAt("afterRst", 0, 48'h40_00000000_95);

    $display("[TB] randomized frames");
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      ridx = 6'($urandom);
      rarg = 32'($urandom);
      applyStimulus(ridx, rarg, 1);
      checkFrameAt($sformatf("rand%0d", r), 0, frameOf(ridx, rarg));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
